// File: rtl/branch_logic.sv
// Branch resolution: decodes branch opcodes against ALU Z/N flags
// and registers the PC-select for the fetch stage.
module branch_logic #(
  parameter logic [4:0] OP_BEQ = 5'b10011,
  parameter logic [4:0] OP_BLT = 5'b10100,
  parameter logic [4:0] OP_BGT = 5'b10101,
  parameter logic [4:0] OP_BNE = 5'b10110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic [1:0] flags,
  output logic       pc_branch_sel_out
);

  logic z;
  logic n;
  logic take;

  assign z = flags[1];
  assign n = flags[0];

  // Opcode is decoded first; flags only gate a matched branch.
  always_comb begin
    take = 1'b0;
    unique case (1'b1)
      (opcode == OP_BEQ): take = z;
      (opcode == OP_BNE): take = ~z;
      (opcode == OP_BLT): take = n;
      (opcode == OP_BGT): take = ~n;
      default:            take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_branch_sel_out <= 1'b0;
    end else begin
      pc_branch_sel_out <= take;
    end
  end

endmodule

// File: tb/tb_branch_logic.sv
// Self-checking bench for branch_logic: directed table, hand
// sequences for reset/latency, and random stimulus vs truth tables.
module tb_branch_logic;

  localparam logic [4:0] BEQ = 5'b10011;
  localparam logic [4:0] BLT = 5'b10100;
  localparam logic [4:0] BGT = 5'b10101;
  localparam logic [4:0] BNE = 5'b10110;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [1:0] fl;
    logic       exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] opcode;
  logic [1:0] flags;
  logic       out;

  int ncmp;
  int nerr;

  branch_logic dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .opcode           (opcode),
    .flags            (flags),
    .pc_branch_sel_out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truth table per opcode, bit index = flags value {Z,N}.
  function automatic logic model(input logic [4:0] op,
                                 input logic [1:0] fl);
    logic [3:0] tt;
    tt = 4'b0000;
    if (op == BEQ) tt = 4'b1100;
    if (op == BNE) tt = 4'b0011;
    if (op == BLT) tt = 4'b1010;
    if (op == BGT) tt = 4'b0101;
    return tt[fl];
  endfunction

  task automatic check(input string name, input logic act,
                       input logic exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic two_edges();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[$];

  initial begin
    logic exp;
    ncmp = 0;
    nerr = 0;

    vecs.push_back('{"beq_10", BEQ, 2'b10, 1'b1});
    vecs.push_back('{"beq_11", BEQ, 2'b11, 1'b1});
    vecs.push_back('{"beq_01", BEQ, 2'b01, 1'b0});
    vecs.push_back('{"beq_00", BEQ, 2'b00, 1'b0});
    vecs.push_back('{"bne_01", BNE, 2'b01, 1'b1});
    vecs.push_back('{"bne_00", BNE, 2'b00, 1'b1});
    vecs.push_back('{"bne_11", BNE, 2'b11, 1'b0});
    vecs.push_back('{"bne_10", BNE, 2'b10, 1'b0});
    vecs.push_back('{"blt_01", BLT, 2'b01, 1'b1});
    vecs.push_back('{"blt_11", BLT, 2'b11, 1'b1});
    vecs.push_back('{"blt_10", BLT, 2'b10, 1'b0});
    vecs.push_back('{"blt_00", BLT, 2'b00, 1'b0});
    vecs.push_back('{"bgt_00", BGT, 2'b00, 1'b1});
    vecs.push_back('{"bgt_10", BGT, 2'b10, 1'b1});
    vecs.push_back('{"bgt_01", BGT, 2'b01, 1'b0});
    vecs.push_back('{"bgt_11", BGT, 2'b11, 1'b0});
    vecs.push_back('{"nop_00", 5'b00000, 2'b00, 1'b0});
    vecs.push_back('{"nop_01", 5'b00000, 2'b01, 1'b0});
    vecs.push_back('{"nop_10", 5'b00000, 2'b10, 1'b0});
    vecs.push_back('{"nop_11", 5'b00000, 2'b11, 1'b0});

    // Reset held with a taken BEQ on the inputs.
    rst_n  = 1'b0;
    opcode = BEQ;
    flags  = 2'b10;
    #1;
    check("rst_init", out, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_hold", out, 1'b0);
    end
    rst_n = 1'b1;
    two_edges();
    check("rst_release", out, 1'b1);

    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      flags  = vecs[i].fl;
      two_edges();
      check(vecs[i].name, out, vecs[i].exp);
    end

    // Latency: BEQ taken shows up exactly one edge later.
    opcode = 5'b00000;
    flags  = 2'b11;
    two_edges();
    opcode = BEQ;
    flags  = 2'b10;
    #1;
    check("lat_before", out, 1'b0);
    @(posedge clk);
    #1;
    check("lat_after", out, 1'b1);
    // Async clear between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clr", out, 1'b0);
    @(posedge clk);
    #1;
    check("async_hold", out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("async_rel", out, 1'b1);

    // Random: inputs change on negedge, sampled at the next posedge.
    @(negedge clk);
    exp = out;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      check("rnd", out, exp);
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 3))
          0: opcode = BEQ;
          1: opcode = BNE;
          2: opcode = BLT;
          default: opcode = BGT;
        endcase
      end else begin
        opcode = 5'($urandom);
      end
      flags = 2'($urandom);
      rst_n = ($urandom_range(0, 19) != 0);
      #1;
      if (!rst_n) check("rnd_async", out, 1'b0);
      exp = rst_n ? model(opcode, flags) : 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
